// File: rtl/register_file_rv32.sv
// 32 x 32-bit integer register file: two combinational read ports plus a debug port, one synchronous write port.
// Optional write-first bypass on all read ports is enabled by defining REGFILE_WRITE_BYPASS_EN.
module register_file_rv32 #(
    parameter  int WIDTH = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RegWrite,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic [AW-1:0]    RA1,
    input  logic [AW-1:0]    RA2,
    input  logic [AW-1:0]    DbgAddr,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic [WIDTH-1:0] DbgData,
    output logic [15:0]      WrCount
);

    localparam int NPORTS = 3;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [15:0]      wr_cnt_q, wr_cnt_d;
    logic             wr_en;
    logic [AW-1:0]    rd_addr [NPORTS];
    logic [WIDTH-1:0] rd_data [NPORTS];

    // Out-of-range and x0 targets are neither stored nor counted.
    assign wr_en = RegWrite && (WA != '0) && (int'(WA) < NREGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[WA] <= WD;
        end
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (wr_en && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_addr[0] = RA1;
    assign rd_addr[1] = RA2;
    assign rd_addr[2] = DbgAddr;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_rd_port
            always_comb begin
                rd_data[gi] = '0;
                if ((rd_addr[gi] != '0) && (int'(rd_addr[gi]) < NREGS)) begin
                    rd_data[gi] = regs_q[rd_addr[gi]];
                end
`ifdef REGFILE_WRITE_BYPASS_EN
                // wr_en already excludes x0, so register 0 still reads zero.
                if (wr_en && (rd_addr[gi] == WA)) begin
                    rd_data[gi] = WD;
                end
`endif
            end
        end
    endgenerate

    assign RD1     = rd_data[0];
    assign RD2     = rd_data[1];
    assign DbgData = rd_data[2];
    assign WrCount = wr_cnt_q;

endmodule

// File: tb/tb_register_file_rv32.sv
// Directed self-checking bench for register_file_rv32; build with REGFILE_WRITE_BYPASS_EN to cover the bypass variant.
module tb_register_file_rv32;

    logic        clk;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  WA;
    logic [31:0] WD;
    logic [4:0]  RA1;
    logic [4:0]  RA2;
    logic [4:0]  DbgAddr;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] DbgData;
    logic [15:0] WrCount;

    int checks;
    int errors;

    register_file_rv32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RegWrite (RegWrite),
        .WA       (WA),
        .WD       (WD),
        .RA1      (RA1),
        .RA2      (RA2),
        .DbgAddr  (DbgAddr),
        .RD1      (RD1),
        .RD2      (RD2),
        .DbgData  (DbgData),
        .WrCount  (WrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        RegWrite = 1'b1;
        WA       = a;
        WD       = d;
        tick();
        RegWrite = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] coll_exp;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b1;
        RegWrite = 1'b0;
        WA       = '0;
        WD       = '0;
        RA1      = '0;
        RA2      = '0;
        DbgAddr  = '0;

        #2 rst_n = 1'b0;
        RA1 = 5'd5; RA2 = 5'd7; DbgAddr = 5'd31;
        #1;
        check("reset_rd1", RD1, 32'h0);
        check("reset_rd2", RD2, 32'h0);
        check("reset_dbg", DbgData, 32'h0);
        check("reset_cnt", {16'h0, WrCount}, 32'd0);
        #5 rst_n = 1'b1;

        write_reg(5'd5, 32'hDEADBEEF);
        RA1 = 5'd5; RA2 = 5'd5; #1;
        check("wr5_rd1", RD1, 32'hDEADBEEF);
        check("wr5_rd2", RD2, 32'hDEADBEEF);
        check("wr5_cnt", {16'h0, WrCount}, 32'd1);

        write_reg(5'd0, 32'hFFFFFFFF);
        RA1 = 5'd0; #1;
        check("x0_rd1", RD1, 32'h0);
        check("x0_cnt", {16'h0, WrCount}, 32'd1);

        write_reg(5'd3, 32'd10);
        write_reg(5'd4, 32'd20);
        RA1 = 5'd3; RA2 = 5'd4; DbgAddr = 5'd3; #1;
        check("ports_rd1", RD1, 32'd10);
        check("ports_rd2", RD2, 32'd20);
        check("ports_dbg", DbgData, 32'd10);
        check("ports_cnt", {16'h0, WrCount}, 32'd3);

        write_reg(5'd7, 32'd1);
`ifdef REGFILE_WRITE_BYPASS_EN
        coll_exp = 32'd2;
`else
        coll_exp = 32'd1;
`endif
        RegWrite = 1'b1; WA = 5'd7; WD = 32'd2; RA2 = 5'd7; DbgAddr = 5'd7; RA1 = 5'd3; #1;
        check("coll_pre_rd2", RD2, coll_exp);
        check("coll_pre_dbg", DbgData, coll_exp);
        check("coll_pre_rd1", RD1, 32'd10);
        tick();
        RegWrite = 1'b0; #1;
        check("coll_post_rd2", RD2, 32'd2);
        check("coll_cnt", {16'h0, WrCount}, 32'd5);

        RegWrite = 1'b1; WA = 5'd0; WD = 32'h55AA55AA; RA1 = 5'd0; #1;
        check("x0_bypass_rd1", RD1, 32'h0);
        tick();
        RegWrite = 1'b0; #1;
        check("x0_bypass_cnt", {16'h0, WrCount}, 32'd5);

        WA = 5'd3; WD = 32'd99; RA1 = 5'd3;
        tick();
        check("nowrite_rd1", RD1, 32'd10);
        check("nowrite_cnt", {16'h0, WrCount}, 32'd5);

        // Asynchronous reset in the middle of a cycle, with no clock edge before checking.
        RA1 = 5'd3; RA2 = 5'd4; DbgAddr = 5'd5;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_rd1", RD1, 32'h0);
        check("async_rst_rd2", RD2, 32'h0);
        check("async_rst_dbg", DbgData, 32'h0);
        check("async_rst_cnt", {16'h0, WrCount}, 32'd0);
        #1 rst_n = 1'b1;

        write_reg(5'd9, 32'h12345678);
        RA1 = 5'd9; #1;
        check("post_rst_rd1", RD1, 32'h12345678);
        check("post_rst_cnt", {16'h0, WrCount}, 32'd1);

        RegWrite = 1'b1; WA = 5'd1;
        for (int i = 0; i < 65534; i++) begin
            WD = i;
            tick();
        end
        RegWrite = 1'b0; #1;
        check("sat_reach_cnt", {16'h0, WrCount}, 32'h0000FFFF);
        RegWrite = 1'b1;
        for (int i = 0; i < 4; i++) begin
            WD = 32'hA000_0000 + i;
            tick();
        end
        RegWrite = 1'b0; RA2 = 5'd1; #1;
        check("sat_hold_cnt", {16'h0, WrCount}, 32'h0000FFFF);
        check("sat_last_rd2", RD2, 32'hA000_0003);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
